// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared constants and types for the fetch stage and the memory-side checkers.
//   IM_BASE / IM_DEPTH / RESET_PC : instruction ROM placement and boot PC
//   IM_LAST                       : byte address of the last legal ROM word
//   fetch_state_t                 : fetch sequencer states (RUN, HOLD, FAULT)
//   NOP_WORD                      : word handed to F/D when nothing valid is fetched
// -----------------------------------------------------------------------------
package cpu_pkg;

   localparam logic [31:0] IM_BASE  = 32'h0000_3000;
   localparam int          IM_DEPTH = 4096;
   localparam logic [31:0] RESET_PC = 32'h0000_3000;
   localparam logic [31:0] IM_LAST  = IM_BASE + 32'(4 * IM_DEPTH) - 32'd4;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      HOLD  = 2'd1,
      FAULT = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/im_addr_check.sv
// -----------------------------------------------------------------------------
// im_addr_check
// Purely combinational word-address checker. Flags an address that is not
// word aligned or falls outside [BASE, LAST]. All compares are unsigned.
// Usable for both the instruction and the data memory windows.
//   addr : byte address under test
//   bad  : 1 when addr is misaligned or out of range
// -----------------------------------------------------------------------------
module im_addr_check #(
   parameter logic [31:0] BASE = 32'h0000_3000,
   parameter logic [31:0] LAST = 32'h0000_6FFC
) (
   input  logic [31:0] addr,
   output logic        bad
);

   assign bad = (addr[1:0] != 2'b00) | (addr < BASE) | (addr > LAST);

endmodule

// File: rtl/im_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// im_fetch_ctrl
// Fetch-stage sequencer for the instruction ROM. Owns the architectural PC,
// drives the ROM address and qualifies the returned word for the F/D register.
//
// Redirect semantics: i_redir_valid is a one-cycle strobe with no ready side.
// It is always accepted in the cycle it is high: applied to the PC at the next
// edge, or, if F is stalled, parked as a pending redirect (latest one wins) and
// applied at the edge where the stall drops. A live redirect beats a pending
// one. Delay-slot word is already in F, so nothing is flushed.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   i_stall         : hold F, PC does not advance
//   i_redir_valid   : redirect strobe from D
//   i_redir_target  : redirect byte address
//   i_im_instr      : ROM word for o_im_pc (combinational ROM)
//   o_im_pc         : PC register / ROM address
//   o_instr         : fetched word, NOP_WORD unless o_valid
//   o_valid         : o_instr is a legal fetch this cycle
//   o_exc_adel      : current PC misaligned or out of range
//   o_state         : FSM state (fetch_state_t encoding)
// -----------------------------------------------------------------------------
module im_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
   parameter logic [31:0] IM_BASE  = cpu_pkg::IM_BASE,
   parameter int          IM_DEPTH = cpu_pkg::IM_DEPTH
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_stall,
   input  logic        i_redir_valid,
   input  logic [31:0] i_redir_target,
   input  logic [31:0] i_im_instr,
   output logic [31:0] o_im_pc,
   output logic [31:0] o_instr,
   output logic        o_valid,
   output logic        o_exc_adel,
   output logic [1:0]  o_state
);

   import cpu_pkg::*;

   localparam logic [31:0] LAST_PC = IM_BASE + 32'(4 * IM_DEPTH) - 32'd4;

   fetch_state_t state, state_n;
   logic [31:0]  pc, pc_n;
   logic         pend_v, pend_v_n;
   logic [31:0]  pend_tgt, pend_tgt_n;
   logic         bad;

   im_addr_check #(
      .BASE (IM_BASE),
      .LAST (LAST_PC)
   ) u_addr_check (
      .addr (pc),
      .bad  (bad)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= RESET_PC;
         state    <= RUN;
         pend_v   <= 1'b0;
         pend_tgt <= 32'h0;
      end else begin
         pc       <= pc_n;
         state    <= state_n;
         pend_v   <= pend_v_n;
         pend_tgt <= pend_tgt_n;
      end
   end

   always_comb begin
      pc_n       = pc;
      state_n    = state;
      pend_v_n   = pend_v;
      pend_tgt_n = pend_tgt;

      if (state == FAULT) begin
         // Only a redirect leaves FAULT; stall has no effect here.
         if (i_redir_valid) begin
            pc_n     = i_redir_target;
            state_n  = RUN;
            pend_v_n = 1'b0;
         end
      end else if (bad) begin
         // A redirect arriving with the bad PC rescues it instead of faulting.
         pend_v_n = 1'b0;
         if (i_redir_valid) begin
            pc_n    = i_redir_target;
            state_n = RUN;
         end else begin
            state_n = FAULT;
         end
      end else if (i_stall) begin
         state_n = HOLD;
         if (i_redir_valid) begin
            pend_v_n   = 1'b1;
            pend_tgt_n = i_redir_target;
         end
      end else begin
         state_n  = RUN;
         pend_v_n = 1'b0;
         if (i_redir_valid) begin
            pc_n = i_redir_target;
         end else if (pend_v) begin
            pc_n = pend_tgt;
         end else begin
            pc_n = pc + 32'd4;   // wraps modulo 2^32; a wrapped PC then faults
         end
      end
   end

   assign o_im_pc    = pc;
   assign o_exc_adel = bad;
   assign o_valid    = !bad && (state != FAULT);
   assign o_instr    = o_valid ? i_im_instr : NOP_WORD;
   assign o_state    = state;

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_im_fetch_ctrl
// Directed bench for im_fetch_ctrl with a behavioural fetch model checked on
// every cycle, plus literal expectations at the interesting points.
// -----------------------------------------------------------------------------
module tb_im_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_stall;
   logic        i_redir_valid;
   logic [31:0] i_redir_target;
   logic [31:0] i_im_instr;
   logic [31:0] o_im_pc;
   logic [31:0] o_instr;
   logic        o_valid;
   logic        o_exc_adel;
   logic [1:0]  o_state;

   int n_cmp = 0;
   int n_bad = 0;
   logic en = 1'b0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- DUT ----------------
   im_fetch_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .i_stall        (i_stall),
      .i_redir_valid  (i_redir_valid),
      .i_redir_target (i_redir_target),
      .i_im_instr     (i_im_instr),
      .o_im_pc        (o_im_pc),
      .o_instr        (o_instr),
      .o_valid        (o_valid),
      .o_exc_adel     (o_exc_adel),
      .o_state        (o_state)
   );

   // ROM stand-in: content is a scramble of the address so each word is distinct.
   function automatic logic [31:0] rom_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hA5A5, ~a[15:0]};
   endfunction

   assign i_im_instr = rom_word(o_im_pc);

   // ---------------- behavioural model ----------------
   // State kept as plain numbers: 0 running, 1 held, 2 faulted.
   longint unsigned m_pc;
   int              m_st;
   bit              m_pv;
   longint unsigned m_pt;

   function automatic bit m_bad(input longint unsigned a);
      return (a % 4 != 0) || (a < 64'h3000) || (a >= 64'h3000 + 4 * 4096);
   endfunction

   always @(posedge clk) begin
      if (reset) begin
         m_pc = 64'h3000; m_st = 0; m_pv = 0; m_pt = 0;
      end else if (m_st == 2) begin
         if (i_redir_valid) begin m_pc = i_redir_target; m_st = 0; end
      end else if (m_bad(m_pc)) begin
         if (i_redir_valid) begin m_pc = i_redir_target; m_st = 0; end
         else m_st = 2;
      end else if (i_stall) begin
         m_st = 1;
         if (i_redir_valid) begin m_pv = 1; m_pt = i_redir_target; end
      end else begin
         if (i_redir_valid)   m_pc = i_redir_target;
         else if (m_pv)       m_pc = m_pt;
         else                 m_pc = (m_pc + 4) % (64'd1 << 32);
         m_pv = 0;
         m_st = 0;
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      if (en) begin
         logic ev;
         ev = !m_bad(m_pc) && (m_st != 2);
         chk("pc",    o_im_pc,                      32'(m_pc));
         chk("state", {30'h0, o_state},             32'(m_st));
         chk("adel",  {31'h0, o_exc_adel},          {31'h0, m_bad(m_pc)});
         chk("valid", {31'h0, o_valid},             {31'h0, ev});
         chk("instr", o_instr,                      ev ? rom_word(32'(m_pc)) : 32'h0);
      end
   end

   // ---------------- driver ----------------
   task automatic step(input logic st, input logic rv, input logic [31:0] rt);
      i_stall = st; i_redir_valid = rv; i_redir_target = rt;
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step(0, 0, 32'h0);
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1; i_stall = 1'b0; i_redir_valid = 1'b0; i_redir_target = 32'h0;
      step(0, 0, 32'h0);
      en = 1'b1;
      do_reset();

      // Reset state and first unstalled cycles
      chk("rst_pc",    o_im_pc, 32'h3000);
      chk("rst_state", {30'h0, o_state}, 32'd0);
      chk("rst_valid", {31'h0, o_valid}, 32'd1);
      chk("rst_instr", o_instr, rom_word(32'h3000));
      step(0, 0, 32'h0); chk("seq1", o_im_pc, 32'h3004);
      step(0, 0, 32'h0); chk("seq2", o_im_pc, 32'h3008);
      step(0, 0, 32'h0); chk("seq3", o_im_pc, 32'h300C);
      chk("seq3_instr", o_instr, rom_word(32'h300C));

      // Redirect from 3008: next PC is the target, 300C never appears
      do_reset();
      step(0, 0, 32'h0); step(0, 0, 32'h0);
      chk("pre_redir", o_im_pc, 32'h3008);
      step(0, 1, 32'h3100); chk("redir", o_im_pc, 32'h3100);

      // Stall with a captured redirect
      step(0, 1, 32'h3010); chk("to3010", o_im_pc, 32'h3010);
      step(1, 0, 32'h0);
      step(1, 1, 32'h3200);
      chk("stall_pc",    o_im_pc, 32'h3010);
      chk("stall_state", {30'h0, o_state}, 32'd1);
      step(1, 0, 32'h0); chk("stall3_pc", o_im_pc, 32'h3010);
      step(0, 0, 32'h0); chk("pend_apply", o_im_pc, 32'h3200);
      step(0, 0, 32'h0); chk("pend_next",  o_im_pc, 32'h3204);

      // Live redirect beats a pending one; later stalled redirect overwrites
      step(1, 1, 32'h3280);
      step(1, 1, 32'h3200);
      step(0, 1, 32'h3300); chk("live_wins", o_im_pc, 32'h3300);
      step(1, 1, 32'h3400);
      step(1, 1, 32'h3480);
      step(0, 0, 32'h0);    chk("overwrite", o_im_pc, 32'h3480);

      // Misaligned target: accepted, then faults; pc frozen, stall ignored
      step(0, 1, 32'h3002);
      chk("mis_adel",  {31'h0, o_exc_adel}, 32'd1);
      chk("mis_valid", {31'h0, o_valid}, 32'd0);
      chk("mis_instr", o_instr, 32'h0);
      for (int i = 0; i < 5; i++) step(logic'(i % 2), 0, 32'h0);
      chk("fault_pc",    o_im_pc, 32'h3002);
      chk("fault_state", {30'h0, o_state}, 32'd2);
      step(0, 1, 32'h4180);
      chk("recover_pc",    o_im_pc, 32'h4180);
      chk("recover_valid", {31'h0, o_valid}, 32'd1);

      // Upper boundary: 6FFC legal, 7000 faults, reset escapes FAULT
      step(0, 1, 32'h6FF8);
      step(0, 0, 32'h0);
      chk("last_pc",    o_im_pc, 32'h6FFC);
      chk("last_valid", {31'h0, o_valid}, 32'd1);
      step(0, 0, 32'h0);
      chk("over_pc",   o_im_pc, 32'h7000);
      chk("over_adel", {31'h0, o_exc_adel}, 32'd1);
      step(0, 0, 32'h0); chk("over_fault", {30'h0, o_state}, 32'd2);
      do_reset();
      chk("fault_rst_pc",    o_im_pc, 32'h3000);
      chk("fault_rst_state", {30'h0, o_state}, 32'd0);

      // Lower boundary, and redirect arriving with a bad PC rescues it
      step(0, 1, 32'h2FFC); chk("low_adel", {31'h0, o_exc_adel}, 32'd1);
      step(1, 1, 32'h3500); chk("rescue", o_im_pc, 32'h3500);
      chk("rescue_state", {30'h0, o_state}, 32'd0);

      // Reset during a stall discards the pending redirect
      step(1, 1, 32'h3600);
      do_reset();
      step(0, 0, 32'h0); chk("rst_discard", o_im_pc, 32'h3004);

      // Mixed stalls and redirects, checked by the model every cycle
      for (int i = 0; i < 60; i++) begin
         logic [31:0] t;
         t = 32'h3000 + {$urandom_range(0, 4095), 2'b00};
         if ($urandom_range(0, 9) == 0) t = t + 32'd2;
         step(logic'($urandom_range(0, 2) == 0), logic'($urandom_range(0, 3) == 0), t);
      end

      step(0, 0, 32'h0);
      en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
